block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
- Consumes the 8-bit thread_count held by the device control register.
- On kernel start, splits the thread range into fixed-size blocks and hands each block to a free compute core via a reset/start/done handshake.
- Raises a kernel-level done once every block has completed.
- Sits between the device control register and the core array.

Parameters:
NUM_CORES, 2, number of compute cores served (1..8)
THREADS_PER_BLOCK, 4, threads per block; power of two, 1..128
BLK_CNT_W, derived $clog2(THREADS_PER_BLOCK)+1, width of per-core thread count

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-low reset; reset==0 at posedge clears all state
start  input  1  level kernel-start request from host
thread_count  input  8  total threads for the kernel (from device control register)
core_done  input  NUM_CORES  per-core block-complete, level, sampled only while that core's core_start is 1
core_reset  output  NUM_CORES  one-cycle pulse preparing a core for a new block
core_start  output  NUM_CORES  held high while a core executes its block
core_block_id  output  NUM_CORES x 8  block index assigned to each core
core_thread_count  output  NUM_CORES x BLK_CNT_W  active threads in that core's block
done  output  1  kernel complete

Behaviour:
- Reset (reset==0): state IDLE; all slots FREE; every output 0; internal counters 0. Overrides everything, including mid-run.
- Global FSM: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - On start==1, latch tc=thread_count and total=ceil(tc/THREADS_PER_BLOCK), using 9-bit arithmetic; total max 255.
  - Clear dispatched and completed counts.
  - Go to RUN if total>0, else go to DONE.
- RUN:
  - thread_count changes are ignored; the latched tc is used.
  - When completed==total (registered compare), go to DONE.
- DONE:
  - done=1, held.
  - When start==0, go to IDLE; done=0 from the next cycle.
  - A new kernel therefore needs start to drop and re-rise.
- Per-core slot states: FREE, RST, BUSY.
  - core_reset[i] = (slot==RST); core_start[i] = (slot==BUSY).
- FREE->RST: in RUN while dispatched<total.
  - Multiple free slots in one cycle take consecutive block ids in ascending core index, bounded by blocks remaining.
  - Load core_block_id=dispatched+k.
  - Load core_thread_count = THREADS_PER_BLOCK, except the final block, which gets tc - id*THREADS_PER_BLOCK.
  - dispatched advances by the number assigned.
- RST->BUSY: unconditional, next cycle.
- BUSY->FREE: when core_done[i]==1. completed advances by the popcount of finishing cores in that cycle.
  - The slot may be reassigned on the following evaluation, so core_reset rises 2 cycles after the core_done sample.
- Sticky outputs: core_block_id and core_thread_count hold their last values while FREE. core_done on a non-BUSY slot is ignored.
- Latency: start sampled at cycle T -> core_reset at T+2 (T+1 RUN entry, assignment registered at T+2) -> core_start at T+3.
- Last completion sampled at C -> completed==total at C+1 -> done=1 at C+2.

Decomposition:
- Package gpu_dispatch_pkg: typedef enum {IDLE,RUN,DONE} disp_state_t; typedef enum {FREE,RST,BUSY} slot_state_t; localparam THREAD_CNT_W=8.
- Sub-module dispatch_slot, one per core:
  - Inputs: assign pulse, id, count, core_done.
  - Outputs: core_reset, core_start, core_block_id, core_thread_count, free, finish pulse.
- block_dispatcher holds the global FSM, counters, total computation and in-order assignment.

Test Plan:
- thread_count=10, NUM_CORES=2, TPB=4, start held; each core pulses core_done 5 cycles after its core_start:
  - Cores 0/1 get ids 0/1 with count 4, then core 0 gets id 2 with count 2.
  - done rises 2 cycles after the last done sample.
- thread_count=0, start=1 -> no core_reset/core_start ever; done=1 at T+2; start->0 -> done=0 next cycle.
- thread_count=8 -> exactly 2 blocks, both count 4; no third assignment; both cores finish in the same cycle -> completed jumps by 2; done 2 cycles later.
- thread_count=255, NUM_CORES=2 -> 64 blocks dispatched in id order; last block id 63 has count 3; done only after all 64 completions.
- Reset pulled low while cores BUSY -> next cycle all outputs 0 and state IDLE; core_done afterwards ignored; a fresh start runs normally.
- thread_count changed from 10 to 4 during RUN -> dispatch still uses 10 (3 blocks); done not re-triggered while start stays high in DONE.

Source files
------------

// File: rtl/gpu_dispatch_pkg.sv
// Shared types for the kernel block dispatcher and its per-core slots.
package gpu_dispatch_pkg;

  localparam int unsigned THREAD_CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} disp_state_t;
  typedef enum logic [1:0] {FREE, RST, BUSY} slot_state_t;

endpackage

// File: rtl/dispatch_slot.sv
// Per-core slot: tracks one core through reset pulse, execution and completion,
// and holds that core's block id / thread count.
module dispatch_slot
  import gpu_dispatch_pkg::*;
#(
  parameter int unsigned BLK_CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [THREAD_CNT_W-1:0] id,
  input  logic [BLK_CNT_W-1:0]    count,
  input  logic                    core_done,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [THREAD_CNT_W-1:0] core_block_id,
  output logic [BLK_CNT_W-1:0]    core_thread_count,
  output logic                    free,
  output logic                    finish
);

  slot_state_t state, state_next;

  // id/count stay sticky while FREE; only a new assignment overwrites them
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= FREE;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      state <= state_next;
      if (load && state == FREE) begin
        core_block_id     <= id;
        core_thread_count <= count;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE:    if (load) state_next = RST;
      RST:     state_next = BUSY;
      BUSY:    if (core_done) state_next = FREE;
      default: state_next = FREE;
    endcase
  end

  assign core_reset = (state == RST);
  assign core_start = (state == BUSY);
  assign free       = (state == FREE);
  assign finish     = (state == BUSY) && core_done;

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel's thread range into fixed-size blocks and hands them, in id
// order, to free compute cores; raises done once every block has completed.
module block_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned BLK_CNT_W         = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [THREAD_CNT_W-1:0]           thread_count,
  input  logic [NUM_CORES-1:0]              core_done,
  output logic [NUM_CORES-1:0]              core_reset,
  output logic [NUM_CORES-1:0]              core_start,
  output logic [NUM_CORES*THREAD_CNT_W-1:0] core_block_id,
  output logic [NUM_CORES*BLK_CNT_W-1:0]    core_thread_count,
  output logic                              done
);

  localparam int unsigned          TPB_SHIFT = $clog2(THREADS_PER_BLOCK);
  localparam logic [8:0]           TPB_M1    = 9'(THREADS_PER_BLOCK - 1);
  localparam logic [BLK_CNT_W-1:0] FULL_CNT  = BLK_CNT_W'(THREADS_PER_BLOCK);

  disp_state_t state, state_next;

  logic [THREAD_CNT_W-1:0] tc, total, dispatched, completed;
  logic [THREAD_CNT_W-1:0] total_calc, cursor;
  logic [NUM_CORES-1:0]    load, free, finish;
  logic [THREAD_CNT_W-1:0] load_id  [NUM_CORES];
  logic [BLK_CNT_W-1:0]    load_cnt [NUM_CORES];
  logic [3:0]              n_finish;

  assign total_calc = 8'(({1'b0, thread_count} + TPB_M1) >> TPB_SHIFT);

  // Free slots claim consecutive ids in ascending core order; cursor ends at the new dispatched count
  always_comb begin
    load   = '0;
    cursor = dispatched;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      load_id[i]  = cursor;
      load_cnt[i] = (cursor == total - 8'd1)
                  ? BLK_CNT_W'({1'b0, tc} - ({1'b0, cursor} << TPB_SHIFT))
                  : FULL_CNT;
      if (state == RUN && free[i] && cursor < total) begin
        load[i] = 1'b1;
        cursor  = cursor + 8'd1;
      end
    end
  end

  always_comb begin
    n_finish = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      n_finish = n_finish + 4'(finish[i]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (total_calc != '0) ? RUN : DONE;
      RUN:     if (completed == total) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is withheld for the first cycle of a zero-block kernel so it always
  // trails the deciding sample by two cycles, and drops as soon as IDLE is taken
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tc         <= '0;
      total      <= '0;
      dispatched <= '0;
      completed  <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state != IDLE) && (state_next == DONE);
      case (state)
        IDLE: if (start) begin
          tc         <= thread_count;
          total      <= total_calc;
          dispatched <= '0;
          completed  <= '0;
        end
        RUN: begin
          dispatched <= cursor;
          completed  <= completed + 8'(n_finish);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(.BLK_CNT_W(BLK_CNT_W)) u_slot (
      .clk               (clk),
      .reset             (reset),
      .load              (load[g]),
      .id                (load_id[g]),
      .count             (load_cnt[g]),
      .core_done         (core_done[g]),
      .core_reset        (core_reset[g]),
      .core_start        (core_start[g]),
      .core_block_id     (core_block_id[g*THREAD_CNT_W +: THREAD_CNT_W]),
      .core_thread_count (core_thread_count[g*BLK_CNT_W +: BLK_CNT_W]),
      .free              (free[g]),
      .finish            (finish[g])
    );
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: a core responder logs every assignment
// and returns core_done a fixed number of cycles after core_start.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [7:0]        thread_count;
  logic [NC-1:0]     core_done, resp_done, force_done;
  logic [NC-1:0]     core_reset, core_start;
  logic [NC*8-1:0]   core_block_id;
  logic [NC*CW-1:0]  core_thread_count;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int log_core [256];
  int log_id   [256];
  int log_cnt  [256];
  int log_cyc  [256];
  int log_n = 0;
  int n_done = 0;
  int last_sample = -1;
  int lat [NC];
  int age [NC];
  int rst_cyc [NC];
  bit resp_en;

  assign core_done = resp_done | force_done;

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_reset        (core_reset),
    .core_start        (core_start),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Core model: log assignments on core_reset, answer core_done lat cycles after core_start
  initial begin
    resp_done = '0;
    for (int i = 0; i < NC; i++) begin
      age[i] = 0;
      rst_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        resp_done[i] = 1'b0;
        if (core_reset[i] && log_n < 256) begin
          log_core[log_n] = i;
          log_id[log_n]   = int'(core_block_id[i*8 +: 8]);
          log_cnt[log_n]  = int'(core_thread_count[i*CW +: CW]);
          log_cyc[log_n]  = cyc;
          log_n++;
          rst_cyc[i] = cyc;
        end
        if (core_start[i]) begin
          age[i]++;
          if (age[i] == 1) check("start_after_reset", cyc, rst_cyc[i] + 1);
          if (resp_en && age[i] == lat[i] + 1) begin
            resp_done[i] = 1'b1;
            last_sample  = cyc;
            n_done++;
          end
        end else begin
          age[i] = 0;
        end
      end
    end
  end

  task automatic kernel(input logic [7:0] tc_a, input logic [7:0] tc_b,
                        output int t0, output int tdone);
    log_n = 0;
    n_done = 0;
    last_sample = -1;
    thread_count = tc_a;
    start = 1'b1;
    t0 = cyc;
    step();
    thread_count = tc_b;
    tdone = -1;
    for (int n = 0; n < 1500; n++) begin
      if (done) begin
        tdone = cyc;
        break;
      end
      step();
    end
    if (tdone < 0) check("done_timeout", done, 1);
  endtask

  task automatic expect_blk(input int k, input int core, input int id, input int cnt, input int when);
    check("blk_core", log_core[k], core);
    check("blk_id",   log_id[k],   id);
    check("blk_cnt",  log_cnt[k],  cnt);
    check("blk_cyc",  log_cyc[k],  when);
  endtask

  task automatic finish_kernel();
    start = 1'b0;
    step();
    check("done_clear", done, 0);
  endtask

  initial begin
    int t0, td;
    reset = 1'b0;
    start = 1'b0;
    thread_count = '0;
    force_done = '0;
    resp_en = 1'b1;
    lat[0] = 5;
    lat[1] = 5;
    repeat (3) step();
    check("rst_core_reset", core_reset, 0);
    check("rst_core_start", core_start, 0);
    check("rst_block_id", core_block_id, 0);
    check("rst_thread_cnt", core_thread_count, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();

    // 10 threads: ids 0,1 then core 0 takes the partial block
    kernel(8'd10, 8'd10, t0, td);
    check("t10_nblk", log_n, 3);
    expect_blk(0, 0, 0, 4, t0 + 2);
    expect_blk(1, 1, 1, 4, t0 + 2);
    expect_blk(2, 0, 2, 2, t0 + 10);
    check("t10_done_lat", td - t0, 18);
    check("t10_done_after_sample", td - last_sample, 2);
    check("t10_core1_sticky_id", core_block_id[15:8], 1);
    finish_kernel();

    // zero threads: no cores touched, done two cycles after start
    kernel(8'd0, 8'd0, t0, td);
    check("t0_done_lat", td - t0, 2);
    check("t0_nblk", log_n, 0);
    check("t0_core_start", core_start, 0);
    finish_kernel();

    // 8 threads: two full blocks finishing together
    kernel(8'd8, 8'd8, t0, td);
    check("t8_nblk", log_n, 2);
    expect_blk(0, 0, 0, 4, t0 + 2);
    expect_blk(1, 1, 1, 4, t0 + 2);
    check("t8_done_lat", td - t0, 10);
    check("t8_done_after_sample", td - last_sample, 2);
    finish_kernel();

    // 255 threads: 64 blocks in id order, last one holds 3 threads
    lat[0] = 2;
    lat[1] = 3;
    kernel(8'd255, 8'd255, t0, td);
    check("t255_nblk", log_n, 64);
    for (int k = 0; k < 64; k++) begin
      check("t255_id", log_id[k], k);
      check("t255_cnt", log_cnt[k], (k == 63) ? 3 : 4);
    end
    check("t255_completions", n_done, 64);
    check("t255_done_after_sample", td - last_sample, 2);
    finish_kernel();

    // reset while both cores are busy
    lat[0] = 5;
    lat[1] = 5;
    resp_en = 1'b0;
    log_n = 0;
    thread_count = 8'd10;
    start = 1'b1;
    repeat (3) step();
    check("mid_busy", core_start, 2'b11);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("mid_rst_core_reset", core_reset, 0);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_block_id", core_block_id, 0);
    check("mid_rst_thread_cnt", core_thread_count, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b1;
    force_done = 2'b11;
    for (int n = 0; n < 3; n++) begin
      step();
      check("ign_core_start", core_start, 0);
      check("ign_core_reset", core_reset, 0);
      check("ign_done", done, 0);
    end
    force_done = '0;
    resp_en = 1'b1;
    kernel(8'd10, 8'd10, t0, td);
    check("fresh_nblk", log_n, 3);
    check("fresh_done_lat", td - t0, 18);
    finish_kernel();

    // thread_count changes mid-run are ignored; done holds while start stays high
    kernel(8'd10, 8'd4, t0, td);
    check("chg_nblk", log_n, 3);
    expect_blk(2, 0, 2, 2, t0 + 10);
    check("chg_done_lat", td - t0, 18);
    for (int n = 0; n < 4; n++) begin
      step();
      check("hold_done", done, 1);
      check("hold_core_reset", core_reset, 0);
    end
    check("hold_nblk", log_n, 3);
    finish_kernel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
